muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, signed ops via magnitude + sign fix-up.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        accept, dz_start;
  logic        is_div_q, neg_q, neg_rem_q, dz_q, dz_hold;
  logic [63:0] acc;
  logic [31:0] mag_b_q, opa_q;
  logic [32:0] sum, diff;
  logic        ge;
  logic [63:0] step_mul, step_div, prod;
  logic [31:0] res_hi, res_lo;

  function automatic logic [31:0] mag32(input logic signed [31:0] x, input logic sgn);
    logic signed [31:0] n;
    n = -x;
    return (sgn && x[31]) ? n : x;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x, input logic en);
    return en ? -x : x;
  endfunction

  assign accept   = (state == IDLE) && start;
  assign dz_start = op[1] && (busB == 32'd0);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = dz_start ? FINISH : CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FINISH;
      FINISH:  if (!dz_hold) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum      = {1'b0, acc[63:32]} + {1'b0, mag_b_q};
    step_mul = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
    diff     = acc[63:31] - {1'b0, mag_b_q};
    ge       = acc[63] | ~diff[32];
    step_div = ge ? {diff[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    prod     = neg64(acc, neg_q);
    if (dz_q) begin
      res_hi = opa_q;
      res_lo = 32'hFFFF_FFFF;
    end else if (is_div_q) begin
      res_hi = neg32(acc[63:32], neg_rem_q);
      res_lo = neg32(acc[31:0], neg_q);
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      dz_hold   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FINISH) && !dz_hold;
      if (accept) begin
        cnt       <= 5'd0;
        is_div_q  <= op[1];
        neg_q     <= op[0] && (busA[31] ^ busB[31]);
        neg_rem_q <= op[0] && busA[31];
        dz_q      <= dz_start;
        // divide-by-zero lingers one extra cycle in FINISH so done lands two edges after start
        dz_hold   <= dz_start;
        if (!dz_start) div_zero <= 1'b0;
      end else begin
        if (state == CALC) cnt <= cnt + 5'd1;
        if (state == FINISH) dz_hold <= 1'b0;
      end
      if (state == FINISH && !dz_hold) begin
        hi       <= res_hi;
        lo       <= res_lo;
        div_zero <= dz_q;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc     <= {32'd0, mag32(busA, op[0])};
      mag_b_q <= mag32(busB, op[0]);
      opa_q   <= busA;
    end else if (state == CALC) begin
      acc <= is_div_q ? step_div : step_mul;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/div_zero queued at start, compared at done.
module tb_muldiv_unit;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] busA = '0, busB = '0, wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  int checks = 0, passes = 0;

  typedef struct packed {logic [31:0] hi; logic [31:0] lo; logic dz;} exp_t;
  exp_t sbq[$];

  muldiv_unit dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .busA(busA), .busB(busB),
                   .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
                   .div_zero(div_zero), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ua, ub, up;
    longint sa, sb, sp, q, r;
    e.dz = 1'b0;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    if (o[1] && b == 32'd0) begin
      e.dz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
    end else if (o == 2'd0) begin
      up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0];
    end else if (o == 2'd1) begin
      sp = sa * sb; e.hi = sp[63:32]; e.lo = sp[31:0];
    end else if (o == 2'd2) begin
      e.lo = a / b; e.hi = a % b;
    end else begin
      q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0];
    end
    return e;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Accept happens at the edge inside this task; operands are scrambled afterwards.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    op = o; busA = a; busB = b; start = 1'b1;
    sbq.push_back(e);
    tick();
    start = 1'b0; op = 2'($urandom); busA = $urandom; busB = $urandom;
  endtask

  task automatic wait_done(output int lat, output int bcnt, output bit ok);
    lat = 0; ok = 1'b0; bcnt = busy ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      tick(); lat++;
      if (done) begin ok = 1'b1; break; end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; #2 rst_n = 1'b0; #1;
    checks++; if ({busy, done, div_zero} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {busy, done, div_zero}); else passes++;
    checks++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); else passes++;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_arith;
    logic [1:0] to [10] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd2, 2'd1};
    logic [31:0] ta [10] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000,
                             32'h80000000, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] tb [10] = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd7, 32'hFFFFFFFF,
                             32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF};
    logic [63:0] tr [10] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFF_FFFFFFFD,
                             64'h00000002_0000000E, 64'h00000000_80000000, 64'h40000000_00000000,
                             64'h00000001_FFFFFFFD, 64'hFFFFFFFF_00000003, 64'h00000000_FFFFFFFF,
                             64'hFFFFFFFF_80000001};
    int lat, bcnt; bit ok; exp_t e;
    for (int i = 0; i < 10; i++) begin
      e.hi = tr[i][63:32]; e.lo = tr[i][31:0]; e.dz = 1'b0;
      issue(to[i], ta[i], tb[i], e);
      wait_done(lat, bcnt, ok);
      e = sbq.pop_front();
      checks++; if (!ok || lat != 33) $display("FAIL arith%0d_latency: got %0d expected 33", i, lat); else passes++;
      checks++; if (bcnt != 33) $display("FAIL arith%0d_busy_cycles: got %0d expected 33", i, bcnt); else passes++;
      checks++; if ({hi, lo} !== {e.hi, e.lo}) $display("FAIL arith%0d_result: got %h expected %h", i, {hi, lo}, {e.hi, e.lo}); else passes++;
      checks++; if ({busy, div_zero} !== 2'b00) $display("FAIL arith%0d_flags: got %b expected 00", i, {busy, div_zero}); else passes++;
    end
  endtask

  task automatic test_direct_write;
    logic [31:0] lo0;
    lo0 = lo;
    hi_we = 1'b1; wdata = 32'h1111_1111; tick(); hi_we = 1'b0;
    checks++; if ({hi, lo} !== {32'h1111_1111, lo0}) $display("FAIL mthi: got %h expected %h", {hi, lo}, {32'h1111_1111, lo0}); else passes++;
    lo_we = 1'b1; wdata = 32'h2222_2222; tick(); lo_we = 1'b0;
    checks++; if ({hi, lo} !== 64'h11111111_22222222) $display("FAIL mtlo: got %h expected 1111111122222222", {hi, lo}); else passes++;
  endtask

  task automatic test_write_with_start;
    int lat, bcnt; bit ok; exp_t e;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    issue(2'd0, 32'd6, 32'd7, model(2'd0, 32'd6, 32'd7));
    hi_we = 1'b0; lo_we = 1'b0;
    checks++; if ({hi, lo} !== {2{32'h5A5A_5A5A}}) $display("FAIL wr_start_direct: got %h expected 5a5a5a5a5a5a5a5a", {hi, lo}); else passes++;
    wait_done(lat, bcnt, ok);
    e = sbq.pop_front();
    checks++; if (!ok || {hi, lo} !== {e.hi, e.lo}) $display("FAIL wr_start_result: got %h expected %h", {hi, lo}, {e.hi, e.lo}); else passes++;
  endtask

  task automatic test_busy_ignore;
    int lat; exp_t e;
    hi_we = 1'b1; wdata = 32'h0000_AAAA; tick(); hi_we = 1'b0;
    issue(2'd0, 32'd3, 32'd4, model(2'd0, 32'd3, 32'd4));
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      start = (k == 10); hi_we = (k == 12);
      if (k == 10) begin op = 2'd2; busA = 32'd100; busB = 32'd0; end
      if (k == 12) wdata = 32'hDEAD_BEEF;
      tick();
      start = 1'b0; hi_we = 1'b0;
      if (k == 12) begin
        checks++; if (hi !== 32'h0000_AAAA) $display("FAIL busy_mthi_ignored: got %h expected 0000aaaa", hi); else passes++;
      end
      if (done) begin lat = k; break; end
    end
    e = sbq.pop_front();
    checks++; if (lat != 33) $display("FAIL busy_latency: got %0d expected 33", lat); else passes++;
    checks++; if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) $display("FAIL busy_result: got %h expected %h", {hi, lo, div_zero}, {e.hi, e.lo, e.dz}); else passes++;
    tick();
    checks++; if ({busy, done} !== 2'b00) $display("FAIL busy_no_restart: got %b expected 00", {busy, done}); else passes++;
  endtask

  task automatic test_div_zero;
    int lat, bcnt; bit ok; exp_t e;
    issue(2'd2, 32'd7, 32'd0, model(2'd2, 32'd7, 32'd0));
    wait_done(lat, bcnt, ok);
    e = sbq.pop_front();
    checks++; if (!ok || lat != 2) $display("FAIL dz_latency: got %0d expected 2", lat); else passes++;
    checks++; if ({hi, lo, div_zero} !== {32'd7, 32'hFFFFFFFF, 1'b1}) $display("FAIL dz_result: got %h expected %h", {hi, lo, div_zero}, {32'd7, 32'hFFFFFFFF, 1'b1}); else passes++;
    tick();
    checks++; if (div_zero !== 1'b1) $display("FAIL dz_sticky: got %b expected 1", div_zero); else passes++;
    issue(2'd0, 32'd2, 32'd3, model(2'd0, 32'd2, 32'd3));
    checks++; if (div_zero !== 1'b0) $display("FAIL dz_clear: got %b expected 0", div_zero); else passes++;
    wait_done(lat, bcnt, ok);
    e = sbq.pop_front();
    checks++; if (!ok || {hi, lo} !== {e.hi, e.lo}) $display("FAIL dz_next_mult: got %h expected %h", {hi, lo}, {e.hi, e.lo}); else passes++;
  endtask

  task automatic test_back_to_back;
    int lat, bcnt, want; bit ok; exp_t e;
    logic [1:0] o; logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom); a = $urandom;
      b = (i == 3) ? 32'd0 : ((i % 2) ? $urandom_range(1, 1000) : $urandom);
      want = (o[1] && b == 32'd0) ? 2 : 33;
      issue(o, a, b, model(o, a, b));
      wait_done(lat, bcnt, ok);
      e = sbq.pop_front();
      checks++; if (!ok || lat != want) $display("FAIL b2b%0d_latency: got %0d expected %0d", i, lat, want); else passes++;
      checks++; if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) $display("FAIL b2b%0d_result op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, {hi, lo, div_zero}, {e.hi, e.lo, e.dz}); else passes++;
    end
  endtask

  task automatic test_reset_abort;
    int lat, bcnt; bit ok; exp_t e;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678; tick(); hi_we = 1'b0; lo_we = 1'b0;
    issue(2'd3, 32'hFFFFFF00, 32'd9, model(2'd3, 32'hFFFFFF00, 32'd9));
    for (int k = 0; k < 19; k++) tick();
    rst_n = 1'b0; #1;
    sbq.delete();
    checks++; if ({busy, done, hi, lo} !== 66'd0) $display("FAIL abort_immediate: got %h expected 0", {busy, done, hi, lo}); else passes++;
    tick();
    checks++; if ({busy, done} !== 2'b00) $display("FAIL abort_no_done: got %b expected 00", {busy, done}); else passes++;
    rst_n = 1'b1;
    issue(2'd3, 32'hFFFFFF00, 32'd9, model(2'd3, 32'hFFFFFF00, 32'd9));
    wait_done(lat, bcnt, ok);
    e = sbq.pop_front();
    checks++; if (!ok || lat != 33) $display("FAIL abort_restart_latency: got %0d expected 33", lat); else passes++;
    checks++; if ({hi, lo} !== {e.hi, e.lo}) $display("FAIL abort_restart_result: got %h expected %h", {hi, lo}, {e.hi, e.lo}); else passes++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_direct_write();
    test_write_with_start();
    test_busy_ignore();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
